ifu: RTL and testbench
======================

# ifu

Instruction fetch unit of the multi-cycle NPC core, directly upstream of the decoder. It holds the architectural PC, issues one 32-bit instruction read per instruction over an AXI4-Lite-style read channel, and presents the fetched word plus its PC to the decoder with a valid/ready handshake. It then waits for the writeback stage to return the next PC before fetching again.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset; first fetch address.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pc_next_valid  in  1  writeback presents the next PC this cycle.
- pc_next  in  32  next PC from writeback/branch logic.
- araddr  out  32  read address.
- arvalid  out  1  read address valid.
- arready  in  1  memory accepts the address.
- rdata  in  32  read data.
- rresp  in  2  read response; 2'b00 = OKAY.
- rvalid  in  1  read data valid.
- rready  out  1  IFU accepts read data.
- inst_valid  out  1  instruction and pc valid toward the decoder.
- inst_ready  in  1  decoder/execute path accepts the instruction.
- instruction  out  32  fetched instruction word.
- pc  out  32  PC of `instruction`.
- fetch_err  out  1  sticky flag: a fetch returned a non-OKAY rresp.

## Operation
- FSM states: IDLE, AR, R, OUT, WAIT. All outputs are registered or decoded from state only.
- IDLE: reset state. Unconditionally goes to AR on the first clock edge after rst_n deasserts.
- AR: arvalid=1 and araddr={pc[31:2],2'b00}. On arvalid&&arready, go to R. araddr is stable while arvalid is high.
- R: rready=1. On rvalid: capture instruction<=rdata (or 32'h0010_0073 ebreak if rresp!=0, which also sets fetch_err), then go to OUT.
- OUT: inst_valid=1. instruction and pc are stable until inst_ready. On inst_ready, go to WAIT.
- WAIT: on pc_next_valid, pc<=pc_next, then go to AR.
- pc_next_valid outside WAIT is ignored (protocol error, no state change).
- pc_next[1:0] are stored in pc but masked on araddr. No misalignment trap is taken here.
- rresp values 2'b01/2'b10/2'b11 are all treated as errors.
- fetch_err clears only on reset.
- Exactly one outstanding read at any time. No prefetch, no buffering beyond the one instruction register.

## Timing
- Reset values: arvalid=0, rready=0, inst_valid=0, instruction=32'h0, pc=RESET_PC, araddr=RESET_PC, fetch_err=0, state=IDLE.
- Reset is asynchronous: all outputs take their reset values immediately when rst_n falls, including mid-transaction. An in-flight AXI transaction is abandoned. On release, fetch restarts at RESET_PC via IDLE.
- Minimum latency, with arready and rvalid each high on the first possible cycle:
  - AR entered at cycle n, address handshake at n.
  - rready at n+1, data handshake at n+1.
  - inst_valid at n+2.
- Minimum turnaround: inst_ready at cycle m, WAIT at m+1. If pc_next_valid is high at m+1, arvalid at m+2.
- rvalid is only sampled in R. Data arriving in any other state is ignored.
- inst_valid stays high for every cycle inst_ready is low. No drop without acceptance.

## Configuration
- IFU_PERF_EN defined: adds two outputs.
  - perf_fetch_cnt[31:0]: increments on each rvalid&&rready.
  - perf_stall_cnt[31:0]: increments on each cycle in AR or R without a completing handshake.
  - Both reset to 0 and wrap modulo 2^32.
- IFU_PERF_EN undefined: ports and counters are absent. All other behaviour is identical.

## Test plan
- Reset release, arready=1, rvalid=1 with rdata=32'h0000_0413:
  - araddr=32'h8000_0000 with arvalid in cycle 1 after IDLE.
  - inst_valid=1, instruction=32'h0000_0413, pc=32'h8000_0000 two cycles later.
- Backpressure, inst_ready held low 5 cycles: inst_valid, instruction and pc stay constant for all 5 cycles. No new arvalid.
- Slow memory, arready after 3 cycles and rvalid after 4: araddr is stable throughout. With IFU_PERF_EN, perf_stall_cnt=7 and perf_fetch_cnt=1.
- rresp=2'b10 on a fetch: instruction=32'h0010_0073 and fetch_err=1. fetch_err stays 1 through subsequent OKAY fetches.
- Redirects:
  - pc_next_valid pulsed in OUT with pc_next=32'h8000_0100: ignored.
  - pulsed in WAIT with pc_next=32'h8000_0102: next araddr=32'h8000_0100 and pc=32'h8000_0102.
- rst_n asserted while in R: arvalid=0, rready=0, pc=RESET_PC immediately. Refetch from 32'h8000_0000 after release.

Source files
------------

// File: rtl/ifu.sv
// Instruction fetch unit: holds the PC, issues one AXI4-Lite-style read per instruction
// and hands the word to the decoder. Define IFU_PERF_EN to add fetch/stall counters.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_next_valid,
  input  logic [31:0] pc_next,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        fetch_err
`ifdef IFU_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    OUT  = 3'd3,
    WAIT = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instruction_q, instruction_d;
  logic        fetch_err_q, fetch_err_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        inst_valid_q, inst_valid_d;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instruction_d = instruction_q;
    fetch_err_d   = fetch_err_q;
    case (state_q)
      IDLE: state_d = AR;
      AR: begin
        if (arready) state_d = R;
      end
      R: begin
        if (rvalid) begin
          state_d = OUT;
          if (rresp != 2'b00) begin
            instruction_d = EBREAK;
            fetch_err_d   = 1'b1;
          end else begin
            instruction_d = rdata;
          end
        end
      end
      OUT: begin
        if (inst_ready) state_d = WAIT;
      end
      WAIT: begin
        if (pc_next_valid) begin
          pc_d    = pc_next;
          state_d = AR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are flopped copies of the next-state decode so they track state_q exactly.
  always_comb begin
    arvalid_d    = (state_d == AR);
    rready_d     = (state_d == R);
    inst_valid_d = (state_d == OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instruction_q <= 32'h0;
      fetch_err_q   <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      inst_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instruction_q <= instruction_d;
      fetch_err_q   <= fetch_err_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      inst_valid_q  <= inst_valid_d;
    end
  end

  // Low PC bits are kept architecturally but never reach the bus.
  assign araddr      = {pc_q[31:2], 2'b00};
  assign arvalid     = arvalid_q;
  assign rready      = rready_q;
  assign inst_valid  = inst_valid_q;
  assign instruction = instruction_q;
  assign pc          = pc_q;
  assign fetch_err   = fetch_err_q;

`ifdef IFU_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (rready_q && rvalid) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if ((arvalid_q && !arready) || (rready_q && !rvalid)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed scenarios plus randomized fetches against a
// transaction-level model of PC, fetched word, sticky error and perf counters.
module tb_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_next_valid = 1'b0;
  logic [31:0] pc_next = 32'h0;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic [1:0]  rresp = 2'b00;
  logic        rvalid = 1'b0;
  logic        rready;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        fetch_err;
`ifdef IFU_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int passCount = 0;
  int failCount = 0;
  int checkCount = 0;

  logic [31:0] modelPc;
  logic        modelErr;
  logic [31:0] modelFetch;
  logic [31:0] modelStall;

  ifu #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_next_valid (pc_next_valid),
    .pc_next       (pc_next),
    .araddr        (araddr),
    .arvalid       (arvalid),
    .arready       (arready),
    .rdata         (rdata),
    .rresp         (rresp),
    .rvalid        (rvalid),
    .rready        (rready),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .instruction   (instruction),
    .pc            (pc),
    .fetch_err     (fetch_err)
`ifdef IFU_PERF_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    modelPc    = RESET_PC;
    modelErr   = 1'b0;
    modelFetch = 32'h0;
    modelStall = 32'h0;
  endtask

  // One complete instruction: address phase, data phase, decoder handoff, then redirect from WAIT.
  task automatic applyStimulus(input int arDelay, input int rDelay, input logic [1:0] resp,
                               input logic [31:0] data, input int holdCycles, input bit junkInOut,
                               input int waitCycles, input logic [31:0] newPc);
    int budget;
    logic [31:0] expAddr;
    logic [31:0] expInst;
    budget = 0;
    while (!arvalid && budget < 8) begin
      step();
      budget++;
    end
    checkOutput("arvalid_seen", {31'b0, arvalid}, 32'd1);
    expAddr = modelPc & 32'hFFFF_FFFC;
    checkOutput("araddr", araddr, expAddr);
    for (int i = 0; i < arDelay; i++) begin
      arready = 1'b0;
      step();
      checkOutput("ar_hold_valid", {31'b0, arvalid}, 32'd1);
      checkOutput("ar_hold_addr", araddr, expAddr);
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    checkOutput("ar_drop", {31'b0, arvalid}, 32'd0);
    checkOutput("rready_on", {31'b0, rready}, 32'd1);
    for (int i = 0; i < rDelay; i++) begin
      rvalid = 1'b0;
      step();
      checkOutput("r_hold_ready", {31'b0, rready}, 32'd1);
      checkOutput("r_hold_nodata", {31'b0, inst_valid}, 32'd0);
    end
    rvalid = 1'b1;
    rdata  = data;
    rresp  = resp;
    step();
    rvalid = 1'b0;
    rresp  = 2'b00;
    rdata  = $urandom;

    expInst    = (resp == 2'b00) ? data : EBREAK;
    modelErr   = modelErr | (resp != 2'b00);
    modelFetch = modelFetch + 32'd1;
    modelStall = modelStall + 32'(arDelay + rDelay);

    checkOutput("inst_valid", {31'b0, inst_valid}, 32'd1);
    checkOutput("instruction", instruction, expInst);
    checkOutput("pc", pc, modelPc);
    checkOutput("fetch_err", {31'b0, fetch_err}, {31'b0, modelErr});
    checkOutput("rready_off", {31'b0, rready}, 32'd0);
`ifdef IFU_PERF_EN
    checkOutput("perf_fetch", perf_fetch_cnt, modelFetch);
    checkOutput("perf_stall", perf_stall_cnt, modelStall);
`endif

    for (int i = 0; i < holdCycles; i++) begin
      inst_ready = 1'b0;
      if (junkInOut && i == 0) begin
        pc_next_valid = 1'b1;
        pc_next       = 32'h8000_0100;
        rvalid        = 1'b1;
      end
      step();
      pc_next_valid = 1'b0;
      rvalid        = 1'b0;
      checkOutput("bp_valid", {31'b0, inst_valid}, 32'd1);
      checkOutput("bp_instruction", instruction, expInst);
      checkOutput("bp_pc", pc, modelPc);
      checkOutput("bp_no_ar", {31'b0, arvalid}, 32'd0);
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    checkOutput("wait_no_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("wait_no_ar", {31'b0, arvalid}, 32'd0);
    for (int i = 0; i < waitCycles; i++) begin
      rvalid = 1'b1;
      step();
      rvalid = 1'b0;
      checkOutput("wait_idle_ar", {31'b0, arvalid}, 32'd0);
      checkOutput("wait_idle_rr", {31'b0, rready}, 32'd0);
    end
    pc_next_valid = 1'b1;
    pc_next       = newPc;
    step();
    pc_next_valid = 1'b0;
    modelPc = newPc;
  endtask

  initial begin
    logic [1:0] resp;
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    resetModel();
    step();
    step();
    checkOutput("rst_arvalid", {31'b0, arvalid}, 32'd0);
    checkOutput("rst_rready", {31'b0, rready}, 32'd0);
    checkOutput("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("rst_instruction", instruction, 32'h0);
    checkOutput("rst_pc", pc, RESET_PC);
    checkOutput("rst_araddr", araddr, RESET_PC);
    checkOutput("rst_fetch_err", {31'b0, fetch_err}, 32'd0);

    // First fetch: arvalid exactly one edge after release, instruction two cycles after that.
    rst_n = 1'b1;
    step();
    checkOutput("first_arvalid", {31'b0, arvalid}, 32'd1);
    checkOutput("first_araddr", araddr, 32'h8000_0000);
    applyStimulus(0, 0, 2'b00, 32'h0000_0413, 0, 1'b0, 0, 32'h8000_0004);

    // Backpressure with an ignored redirect in OUT, then a misaligned redirect from WAIT.
    applyStimulus(0, 0, 2'b00, $urandom, 5, 1'b1, 1, 32'h8000_0102);
    checkOutput("redirect_araddr", araddr, 32'h8000_0100);

    // Slow memory.
    applyStimulus(3, 4, 2'b00, $urandom, 0, 1'b0, 0, 32'h8000_0200);

    // Error response, then an OKAY fetch that must keep the sticky flag.
    applyStimulus(0, 1, 2'b10, $urandom, 0, 1'b0, 0, 32'h8000_0204);
    applyStimulus(1, 0, 2'b00, $urandom, 1, 1'b0, 0, 32'h8000_0208);

    for (int n = 0; n < 20; n++) begin
      resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      applyStimulus($urandom_range(0, 3), $urandom_range(0, 3), resp, $urandom,
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom);
    end

    // Asynchronous reset while waiting for read data.
    checkOutput("pre_rst_arvalid", {31'b0, arvalid}, 32'd1);
    arready = 1'b1;
    step();
    arready = 1'b0;
    checkOutput("pre_rst_rready", {31'b0, rready}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    resetModel();
    checkOutput("async_arvalid", {31'b0, arvalid}, 32'd0);
    checkOutput("async_rready", {31'b0, rready}, 32'd0);
    checkOutput("async_pc", pc, RESET_PC);
    checkOutput("async_inst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("async_fetch_err", {31'b0, fetch_err}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    checkOutput("refetch_arvalid", {31'b0, arvalid}, 32'd1);
    checkOutput("refetch_araddr", araddr, 32'h8000_0000);
    applyStimulus(2, 2, 2'b00, $urandom, 2, 1'b0, 0, 32'h8000_0010);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
